branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor and branch target buffer for the pipelined RV32I core. It replaces the static predict-not-taken policy. During fetch it looks up the current PC and supplies a predicted direction and target. In execute it compares each resolved branch or jump against the prediction carried down the pipeline, raises a mispredict redirect, and trains its tables. A direct-mapped table holds one valid bit, tag, target, jump flag and 2-bit saturating counter per entry.

## Interface

Parameters:
- DATA_WIDTH, 32, PC/target width
- INDEX_BITS, 6, table has 2^INDEX_BITS entries
- TAG_BITS, 8, stored tag width
- HIST_BITS, 6, global history length (used only with BP_GSHARE_EN; must be ≤ INDEX_BITS)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- pc_f_i  in  DATA_WIDTH  fetch-stage PC
- pred_taken_f_o  out  1  predicted taken for pc_f_i
- pred_target_f_o  out  DATA_WIDTH  predicted target (0 when pred_taken_f_o=0)
- update_en_e_i  in  1  execute stage holds a valid branch/JAL/JALR (branch_e|jump_e, already bubble-qualified)
- jalr_e_i  in  1  resolving instruction is JALR
- jump_e_i  in  1  resolving instruction is JAL or JALR
- pc_e_i  in  DATA_WIDTH  PC of resolving instruction
- taken_e_i  in  1  actual outcome
- target_e_i  in  DATA_WIDTH  actual target (pc_target_e or ALU result for JALR)
- pred_taken_e_i  in  1  prediction piped from fetch
- pred_target_e_i  in  DATA_WIDTH  predicted target piped from fetch
- mispredict_e_o  out  1  redirect required; drives flush_d/flush_e
- redirect_pc_e_o  out  DATA_WIDTH  correct next PC
- mispredict_cnt_o  out  32  saturating mispredict counter

## Operation

- Index: idx = pc[INDEX_BITS+1:2]. Tag: pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Lookup is combinational. hit = valid[idx] & tag match.
- pred_taken_f_o = hit & (jflag[idx] | ctr[idx][1]).
- pred_target_f_o = target[idx] when pred_taken_f_o, else 0.
- Mispredict, combinational, gated by update_en_e_i: (taken_e_i ≠ pred_taken_e_i) | (taken_e_i & target_e_i ≠ pred_target_e_i).
- redirect_pc_e_o = taken_e_i ? target_e_i : pc_e_i+4. It is don't-care when mispredict_e_o=0.
- Training happens on the clock edge when update_en_e_i & ~jalr_e_i. JALR is never allocated or trained, so a taken JALR always mispredicts.
  - Hit: ctr saturating +1 if taken, −1 if not (limits 00/11). If taken, target written.
  - Miss and taken: allocate/replace the entry. valid=1, tag and target written, jflag=jump_e_i, ctr=10.
  - Miss and not taken: no change.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- mispredict_cnt_o increments by 1 each cycle mispredict_e_o=1. It holds at 0xFFFF_FFFF.

## Timing

- Prediction: zero-cycle latency, same cycle as pc_f_i.
- Mispredict/redirect: zero-cycle latency in execute. The core redirects PC on the next edge; penalty is 2 cycles, as with today's taken branches.
- A table write on edge N is visible to lookups from cycle N+1.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents. There is no bypass.
- Reset (any cycle, including mid-update): on the next edge all valid=0, all ctr=01, GHR=0, mispredict_cnt_o=0. Any update in that cycle is discarded. Outputs after reset: pred_taken_f_o=0, pred_target_f_o=0. mispredict_e_o follows inputs combinationally.
- A stalled execute stage must present update_en_e_i=0 for repeated cycles so each instruction trains exactly once. This is the integrator's responsibility.

## Configuration

- BP_GSHARE_EN defined:
  - A HIST_BITS global history register shifts in taken_e_i on every training update with jump_e_i=0: ghr <= {ghr[HIST_BITS-2:0], taken_e_i}.
  - Counter index = idx XOR zero-extended ghr.
  - Tag, target, valid and jflag stay indexed by plain idx.
- Undefined: no GHR; counters indexed by idx (bimodal).

## Test plan

- Reset, then lookup pc_f_i=0x100 -> pred_taken_f_o=0, pred_target_f_o=0, mispredict_cnt_o=0.
- Taken BNE at 0x100 to 0x80, not predicted -> mispredict_e_o=1, redirect 0x80, count=1. Next-cycle lookup of 0x100 -> taken, target 0x80.
- Same branch resolves not-taken twice (ctr 10→01→00):
  - First resolution (predicted taken) -> mispredict_e_o=1, redirect 0x104.
  - Prediction then reads not-taken.
  - Second resolution (predicted not-taken) -> mispredict_e_o=0.
- JAL at 0x200 to 0x400 allocated:
  - Afterwards always predicted taken.
  - Matching resolution -> mispredict_e_o=0, count unchanged.
- JALR at 0x300 taken to 0x500 -> mispredict each time, no allocation. Lookup of 0x300 -> not taken.
- Aliasing: 0x100 allocated, then taken branch at 0x100+4·2^INDEX_BITS (different tag) -> entry replaced. 0x100 lookup -> miss. Assert rst_i during an update -> table cleared, count 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor + BTB: combinational fetch lookup, execute-stage mispredict/redirect and training.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor #(
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int HIST_BITS  = 6
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] pc_f_i,
  output logic                  pred_taken_f_o,
  output logic [DATA_WIDTH-1:0] pred_target_f_o,
  input  logic                  update_en_e_i,
  input  logic                  jalr_e_i,
  input  logic                  jump_e_i,
  input  logic [DATA_WIDTH-1:0] pc_e_i,
  input  logic                  taken_e_i,
  input  logic [DATA_WIDTH-1:0] target_e_i,
  input  logic                  pred_taken_e_i,
  input  logic [DATA_WIDTH-1:0] pred_target_e_i,
  output logic                  mispredict_e_o,
  output logic [DATA_WIDTH-1:0] redirect_pc_e_o,
  output logic [31:0]           mispredict_cnt_o
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  typedef logic [INDEX_BITS-1:0] idx_t;

  logic [ENTRIES-1:0]    valid_q;
  logic [ENTRIES-1:0]    jflag_q;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [31:0]           cnt_q, cnt_d;

  idx_t                idx_f, idx_e, cidx_f, cidx_e;
  logic [TAG_BITS-1:0] tag_f, tag_e;
  logic                hit_f, hit_e, train;
  logic [1:0]          ctr_e, ctr_upd;

  assign idx_f = pc_f_i[INDEX_BITS+1:2];
  assign idx_e = pc_e_i[INDEX_BITS+1:2];
  assign tag_f = pc_f_i[TAG_HI:TAG_LO];
  assign tag_e = pc_e_i[TAG_HI:TAG_LO];

  logic unused_pc;
  assign unused_pc = ^{pc_f_i[DATA_WIDTH-1:TAG_HI+1], pc_f_i[1:0],
                       pc_e_i[DATA_WIDTH-1:TAG_HI+1], pc_e_i[1:0]};

  assign train = update_en_e_i & ~jalr_e_i;

`ifdef BP_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  // Only conditional branches carry direction information worth remembering.
  always_comb begin
    ghr_d = ghr_q;
    if (train && !jump_e_i) ghr_d = {ghr_q[HIST_BITS-2:0], taken_e_i};
  end

  always_ff @(posedge clk) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign cidx_f = idx_f ^ idx_t'(ghr_q);
  assign cidx_e = idx_e ^ idx_t'(ghr_q);
`else
  localparam int unused_hist = HIST_BITS;
  assign cidx_f = idx_f;
  assign cidx_e = idx_e;
`endif

  // Fetch lookup
  assign hit_f           = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign pred_taken_f_o  = hit_f && (jflag_q[idx_f] || ctr_q[cidx_f][1]);
  assign pred_target_f_o = pred_taken_f_o ? target_q[idx_f] : '0;

  // Execute resolution
  assign mispredict_e_o  = update_en_e_i &&
                           ((taken_e_i != pred_taken_e_i) ||
                            (taken_e_i && (target_e_i != pred_target_e_i)));
  assign redirect_pc_e_o = taken_e_i ? target_e_i : pc_e_i + DATA_WIDTH'(4);

  assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
  assign ctr_e = ctr_q[cidx_e];

  always_comb begin
    ctr_upd = ctr_e;
    if (taken_e_i && ctr_e != 2'b11)       ctr_upd = ctr_e + 2'd1;
    else if (!taken_e_i && ctr_e != 2'b00) ctr_upd = ctr_e - 2'd1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mispredict_e_o && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Table state; tag/target arrays need no reset since valid gates every use.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      valid_q <= '0;
      jflag_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (train) begin
      if (hit_e) begin
        ctr_q[cidx_e] <= ctr_upd;
        if (taken_e_i) target_q[idx_e] <= target_e_i;
      end else if (taken_e_i) begin
        valid_q[idx_e]  <= 1'b1;
        jflag_q[idx_e]  <= jump_e_i;
        tag_q[idx_e]    <= tag_e;
        target_q[idx_e] <= target_e_i;
        ctr_q[cidx_e]   <= 2'b10;
      end
    end
  end

  assign mispredict_cnt_o = cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (default bimodal build).
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] pc_f_i;
  logic        pred_taken_f_o;
  logic [31:0] pred_target_f_o;
  logic        update_en_e_i, jalr_e_i, jump_e_i, taken_e_i, pred_taken_e_i;
  logic [31:0] pc_e_i, target_e_i, pred_target_e_i;
  logic        mispredict_e_o;
  logic [31:0] redirect_pc_e_o;
  logic [31:0] mispredict_cnt_o;

  int checks = 0;
  int errors = 0;

  branch_predictor dut (
    .clk              (clk),
    .rst_i            (rst_i),
    .pc_f_i           (pc_f_i),
    .pred_taken_f_o   (pred_taken_f_o),
    .pred_target_f_o  (pred_target_f_o),
    .update_en_e_i    (update_en_e_i),
    .jalr_e_i         (jalr_e_i),
    .jump_e_i         (jump_e_i),
    .pc_e_i           (pc_e_i),
    .taken_e_i        (taken_e_i),
    .target_e_i       (target_e_i),
    .pred_taken_e_i   (pred_taken_e_i),
    .pred_target_e_i  (pred_target_e_i),
    .mispredict_e_o   (mispredict_e_o),
    .redirect_pc_e_o  (redirect_pc_e_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt,
                         input logic jmp, input logic jalr);
    update_en_e_i   = 1'b1;
    pc_e_i          = pc;
    taken_e_i       = tk;
    target_e_i      = tgt;
    pred_taken_e_i  = ptk;
    pred_target_e_i = ptgt;
    jump_e_i        = jmp;
    jalr_e_i        = jalr;
    #1;
  endtask

  task automatic idle();
    update_en_e_i = 1'b0;
    jalr_e_i      = 1'b0;
    jump_e_i      = 1'b0;
    taken_e_i     = 1'b0;
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    pc_f_i = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, pred_taken_f_o}, {31'd0, tk});
    chk({tag, "_tgt"}, pred_target_f_o, tgt);
  endtask

  initial begin
    rst_i = 1'b1; pc_f_i = 32'h0; pc_e_i = 32'h0; target_e_i = 32'h0;
    pred_taken_e_i = 1'b0; pred_target_e_i = 32'h0;
    idle();
    step(); step();
    rst_i = 1'b0;
    look("rst_lookup", 32'h100, 1'b0, 32'h0);
    chk("rst_cnt", mispredict_cnt_o, 32'd0);

    // Taken BNE 0x100 -> 0x80, predicted not taken
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("bne_mp", {31'd0, mispredict_e_o}, 32'd1);
    chk("bne_redir", redirect_pc_e_o, 32'h80);
    step(); idle();
    chk("bne_cnt", mispredict_cnt_o, 32'd1);
    look("bne_look", 32'h100, 1'b1, 32'h80);

    // Not taken, predicted taken: ctr 10 -> 01
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0, 1'b0);
    chk("nt1_mp", {31'd0, mispredict_e_o}, 32'd1);
    chk("nt1_redir", redirect_pc_e_o, 32'h104);
    step(); idle();
    chk("nt1_cnt", mispredict_cnt_o, 32'd2);
    look("nt1_look", 32'h100, 1'b0, 32'h0);

    // Not taken again, predicted not taken: ctr 01 -> 00
    resolve(32'h100, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("nt2_mp", {31'd0, mispredict_e_o}, 32'd0);
    step(); idle();
    chk("nt2_cnt", mispredict_cnt_o, 32'd2);
    look("nt2_look", 32'h100, 1'b0, 32'h0);

    // One taken from strong NT: hit moves ctr only to 01, target refreshed but still not taken
    resolve(32'h100, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); idle();
    chk("wk_cnt", mispredict_cnt_o, 32'd3);
    look("wk_look", 32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 32'h88, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); idle();
    look("wk2_look", 32'h100, 1'b1, 32'h88);

    // JAL 0x200 -> 0x400 (aliases index 0, replaces 0x100)
    pc_f_i = 32'h200;
    resolve(32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("jal_mp", {31'd0, mispredict_e_o}, 32'd1);
    chk("jal_nobypass", {31'd0, pred_taken_f_o}, 32'd0);
    step(); idle();
    chk("jal_cnt", mispredict_cnt_o, 32'd5);
    look("jal_look", 32'h200, 1'b1, 32'h400);
    look("alias_miss", 32'h100, 1'b0, 32'h0);
    resolve(32'h200, 1'b1, 32'h400, 1'b1, 32'h400, 1'b1, 1'b0);
    chk("jal_match_mp", {31'd0, mispredict_e_o}, 32'd0);
    step(); idle();
    chk("jal_match_cnt", mispredict_cnt_o, 32'd5);
    look("jal_again", 32'h200, 1'b1, 32'h400);

    // Target mismatch with correct direction still mispredicts
    resolve(32'h200, 1'b1, 32'h404, 1'b1, 32'h400, 1'b1, 1'b0);
    chk("tgt_mp", {31'd0, mispredict_e_o}, 32'd1);
    chk("tgt_redir", redirect_pc_e_o, 32'h404);
    step(); idle();
    look("tgt_look", 32'h200, 1'b1, 32'h404);

    // JALR 0x300 -> 0x500 twice: always mispredicts, never allocated
    for (int i = 0; i < 2; i++) begin
      resolve(32'h300, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1);
      chk("jalr_mp", {31'd0, mispredict_e_o}, 32'd1);
      chk("jalr_redir", redirect_pc_e_o, 32'h500);
      step(); idle();
    end
    chk("jalr_cnt", mispredict_cnt_o, 32'd8);
    look("jalr_look", 32'h300, 1'b0, 32'h0);
    look("jalr_keep", 32'h200, 1'b1, 32'h404);

    // Miss and not taken: no change
    resolve(32'h400, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mnt_mp", {31'd0, mispredict_e_o}, 32'd0);
    step(); idle();
    look("mnt_keep", 32'h200, 1'b1, 32'h404);

    // Gated: update_en low masks mispredict
    update_en_e_i = 1'b0; taken_e_i = 1'b1; pred_taken_e_i = 1'b0; #1;
    chk("gate_mp", {31'd0, mispredict_e_o}, 32'd0);
    idle();

    // Branch at 0x100 replaces JAL entry; lookup 0x200 misses afterwards
    resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); idle();
    look("repl_new", 32'h100, 1'b1, 32'h80);
    look("repl_old", 32'h200, 1'b0, 32'h0);
    chk("repl_cnt", mispredict_cnt_o, 32'd9);

    // Reset during an update discards it and clears everything
    resolve(32'h200, 1'b1, 32'h600, 1'b0, 32'h0, 1'b0, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0; idle();
    chk("rst2_cnt", mispredict_cnt_o, 32'd0);
    look("rst2_a", 32'h100, 1'b0, 32'h0);
    look("rst2_b", 32'h200, 1'b0, 32'h0);

    // After reset ctr=01: a fresh allocation predicts taken (ctr set to 10)
    resolve(32'h140, 1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    step(); idle();
    look("post_rst_alloc", 32'h140, 1'b1, 32'h20);
    chk("post_rst_cnt", mispredict_cnt_o, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule
